mmu_feeder: RTL and testbench

Input-side sequencer for the 4x4 weight-stationary `mmu` systolic array. It accepts weight rows and activation rows over valid/ready handshakes and drives the array's `control`, `wt_arr` and `data_arr` inputs in the order the array needs. Weights are preloaded in reverse row order; activations are streamed with a per-lane diagonal skew; the pipe is then flushed and completion is signalled. It sits directly upstream of `mmu`, and its outputs connect port-for-port.

---
 rtl/mmu_pkg.sv | 30 +++
 rtl/skew_line.sv | 39 +++
 rtl/mmu_feeder.sv | 188 ++++++++++++++++++
 tb/tb_mmu_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_pkg
// Description : Shared array geometry and feeder state encoding for the
//               4x4 weight-stationary mmu and its input-side feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_pkg;

  localparam int MMU_DEPTH     = 4;  // activation lanes
  localparam int MMU_BIT_WIDTH = 8;  // element width
  localparam int MMU_SIZE      = 4;  // weight rows / pipeline stages

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WT_COLLECT = 3'd1,
    WT_SHIFT   = 3'd2,
    STREAM     = 3'd3,
    FLUSH      = 3'd4,
    DONE       = 3'd5
  } state_t;

  // Cycles needed after the last row so that its last lane has left the
  // skew and traversed every array stage.
  function automatic int flush_cycles(input int d, input int s);
    return d - 1 + s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_line
// Description : Per-lane delay line. LEN delay stages followed by one output
//               register, so the total latency is LEN+1 cycles. Synchronous
//               clear returns every stage to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_line #(
  parameter int WIDTH = 8,
  parameter int LEN   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Stage LEN is the output register; stages 0..LEN-1 provide the skew.
  logic [WIDTH-1:0] r_sr [LEN+1];

  // Shift one stage per cycle; clear everything on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEN; k++) begin
        r_sr[k] <= '0;
      end
    end else begin
      r_sr[0] <= i_d;
      for (int k = 1; k <= LEN; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
    end
  end

  assign o_q = r_sr[LEN];

endmodule
`default_nettype wire

// File: rtl/mmu_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mmu_feeder
// Description : Input-side sequencer for the weight-stationary mmu array.
//               Collects weight rows, shifts them in reverse order, streams
//               activations through a per-lane diagonal skew, flushes the
//               pipe and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_feeder
  import mmu_pkg::*;
#(
  parameter int DEPTH     = MMU_DEPTH,
  parameter int BIT_WIDTH = MMU_BIT_WIDTH,
  parameter int SIZE      = MMU_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [BIT_WIDTH*DEPTH-1:0] wt_row,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIT_WIDTH*DEPTH-1:0] in_row,
  input  logic                       in_last,
  output logic                       control,
  output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
  output logic [BIT_WIDTH*DEPTH-1:0] data_arr,
  output logic                       data_vld,
  output logic                       busy,
  output logic                       done
);

  localparam int ROW_W     = BIT_WIDTH * DEPTH;
  localparam int FLUSH_LEN = flush_cycles(DEPTH, SIZE);
  localparam int CNT_MAX   = (FLUSH_LEN > SIZE) ? FLUSH_LEN : SIZE;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [SIZE-1:0][ROW_W-1:0]  r_wbuf;
  logic                        r_wt_ready;
  logic                        r_in_ready;
  logic                        r_control;
  logic [ROW_W-1:0]            r_wt_arr;
  logic                        r_data_vld;
  logic                        r_busy;
  logic                        r_done;

  logic                        w_wt_hs;
  logic                        w_in_hs;
  logic [IDX_W-1:0]            w_widx;
  logic [IDX_W-1:0]            w_ridx;
  logic [BIT_WIDTH-1:0]        w_lane_in  [DEPTH];
  logic [BIT_WIDTH-1:0]        w_lane_out [DEPTH];

  // Ready flags are only ever high in their own state, so they double as
  // the state qualifier for the handshakes.
  assign w_wt_hs = r_wt_ready & wt_valid;
  assign w_in_hs = r_in_ready & in_valid;

  // Write slot during collection; read slot for the next shift cycle,
  // walking the buffer from the last-loaded row back to the first.
  assign w_widx = r_cnt[IDX_W-1:0];
  assign w_ridx = IDX_W'(SIZE - 1) - r_cnt[IDX_W-1:0];

  // Sequencer: state, counter, weight buffer and all control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wbuf     <= '0;
      r_wt_ready <= 1'b0;
      r_in_ready <= 1'b0;
      r_control  <= 1'b0;
      r_wt_arr   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_control <= 1'b0;
      r_wt_arr  <= '0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state    <= WT_COLLECT;
          r_cnt      <= '0;
          r_wt_ready <= 1'b1;
          r_busy     <= 1'b1;
        end
        WT_COLLECT: begin
          if (w_wt_hs) begin
            r_wbuf[w_widx] <= wt_row;
            if (r_cnt == CNT_W'(SIZE - 1)) begin
              // The last row collected is the first one shifted, so it is
              // forwarded straight to the output without a buffer read.
              r_state    <= WT_SHIFT;
              r_wt_ready <= 1'b0;
              r_control  <= 1'b1;
              r_wt_arr   <= wt_row;
              r_cnt      <= CNT_W'(1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        WT_SHIFT: begin
          if (r_cnt == CNT_W'(SIZE)) begin
            r_state    <= STREAM;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_control <= 1'b1;
            r_wt_arr  <= r_wbuf[w_ridx];
            r_cnt     <= r_cnt + CNT_W'(1);
          end
        end
        STREAM: begin
          if (w_in_hs && in_last) begin
            r_state    <= FLUSH;
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
          end
        end
        FLUSH: begin
          if (r_cnt == CNT_W'(FLUSH_LEN - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_wt_ready <= 1'b0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Valid tag travels with lane 0, which has no skew stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_vld <= 1'b0;
    end else begin
      r_data_vld <= w_in_hs;
    end
  end

  // One skew line per lane; lane i (lane 0 in the MSBs) is delayed i cycles
  // ahead of its output register. Zeros enter whenever no row is accepted.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
      assign w_lane_in[gi] = w_in_hs ? in_row[(DEPTH-1-gi)*BIT_WIDTH +: BIT_WIDTH]
                                     : '0;

      skew_line #(
        .WIDTH (BIT_WIDTH),
        .LEN   (gi)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .i_d (w_lane_in[gi]),
        .o_q (w_lane_out[gi])
      );

      assign data_arr[(DEPTH-1-gi)*BIT_WIDTH +: BIT_WIDTH] = w_lane_out[gi];
    end
  endgenerate

  assign wt_ready = r_wt_ready;
  assign in_ready = r_in_ready;
  assign control  = r_control;
  assign wt_arr   = r_wt_arr;
  assign data_vld = r_data_vld;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mmu_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_feeder
// Description : Directed self-checking bench for mmu_feeder (4 lanes,
//               8-bit elements, 4 weight rows).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_feeder;

  logic        clk;
  logic        rst;
  logic        wt_valid;
  logic        wt_ready;
  logic [31:0] wt_row;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_row;
  logic        in_last;
  logic        control;
  logic [31:0] wt_arr;
  logic [31:0] data_arr;
  logic        data_vld;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  mmu_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .wt_valid (wt_valid),
    .wt_ready (wt_ready),
    .wt_row   (wt_row),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_last  (in_last),
    .control  (control),
    .wt_arr   (wt_arr),
    .data_arr (data_arr),
    .data_vld (data_vld),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset asserted for one edge; all outputs must read zero afterwards.
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({wt_ready, in_ready, control, wt_arr, data_arr, data_vld, busy, done} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b ir=%b ctl=%b wt=%h d=%h v=%b busy=%b done=%b, want all 0",
               wt_ready, in_ready, control, wt_arr, data_arr, data_vld, busy, done);
    end
    rst = 1'b0;
  endtask

  // Collect four weight rows, then check the reverse-order shift out.
  // Returns at the negedge of the first STREAM cycle.
  task automatic test_weight_shift(input logic [31:0] r0, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] r3);
    logic [31:0] rows [4];
    int          waited;
    rows = '{r0, r1, r2, r3};
    waited = 0;
    while (wt_ready !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (wt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wt_ready_wait: got %b, want 1 within 30 cycles", wt_ready);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      wt_valid = 1'b1;
      wt_row   = rows[k];
      @(negedge clk);
    end
    wt_valid = 1'b0;
    wt_row   = 32'h0;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (control !== 1'b1 || wt_arr !== rows[3-j]) begin
        n_fail++;
        $display("FAIL wt_shift_%0d: got ctl=%b wt=%h, want ctl=1 wt=%h", j, control, wt_arr, rows[3-j]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (control !== 1'b0 || wt_arr !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wt_shift_end: got ctl=%b wt=%h ir=%b busy=%b, want 0 0 1 1",
               control, wt_arr, in_ready, busy);
    end
  endtask

  // wt_valid held high during STREAM must not be accepted or stored.
  task automatic test_wt_ignored();
    wt_valid = 1'b1;
    wt_row   = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (wt_ready !== 1'b0 || control !== 1'b0) begin
        n_fail++;
        $display("FAIL wt_ignored_%0d: got wr=%b ctl=%b, want 0 0", k, wt_ready, control);
      end
    end
    wt_valid = 1'b0;
    wt_row   = 32'h0;
    n_tests++;
    if (dut.r_wbuf[0] !== 32'h01010101 || dut.r_wbuf[1] !== 32'h02020202 ||
        dut.r_wbuf[2] !== 32'h03030303 || dut.r_wbuf[3] !== 32'h04040404) begin
      n_fail++;
      $display("FAIL wbuf_kept: got %h %h %h %h, want 01010101 02020202 03030303 04040404",
               dut.r_wbuf[0], dut.r_wbuf[1], dut.r_wbuf[2], dut.r_wbuf[3]);
    end
  endtask

  // Two rows back to back, the second last; checks skew, tag, flush, done.
  task automatic test_back_to_back();
    logic [31:0] exp_d [11];
    logic        exp_v [11];
    exp_d = '{32'h0, 32'h11000000, 32'h55220000, 32'h00663300, 32'h00007744,
              32'h00000088, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    in_valid = 1'b1;
    in_row   = 32'h11223344;
    in_last  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (data_arr !== exp_d[k] || data_vld !== exp_v[k] || done !== (k == 9)) begin
        n_fail++;
        $display("FAIL b2b_cycle_%0d: got d=%h v=%b done=%b, want d=%h v=%b done=%b",
                 k, data_arr, data_vld, done, exp_d[k], exp_v[k], (k == 9));
      end
      if (k <= 2) begin
        n_tests++;
        if (in_ready !== (k == 1)) begin
          n_fail++;
          $display("FAIL b2b_in_ready_%0d: got %b, want %b", k, in_ready, (k == 1));
        end
      end
      if (k == 10) begin
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle_busy: got %b, want 0", busy);
        end
      end
      if (k == 1) begin
        in_row  = 32'h55667788;
        in_last = 1'b1;
      end else if (k == 2) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_row   = 32'h0;
      end
    end
  endtask

  // Two idle cycles between rows insert zero rows and clear the tag.
  task automatic test_bubble();
    logic [31:0] exp_d [14];
    logic        exp_v [14];
    exp_d = '{32'h0, 32'hA1000000, 32'h00A20000, 32'h0000A300, 32'hB10000A4,
              32'hC1B20000, 32'h00C2B300, 32'h0000C3B4, 32'h000000C4,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    in_valid = 1'b1;
    in_row   = 32'hA1A2A3A4;
    in_last  = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      n_tests++;
      if (data_arr !== exp_d[k] || data_vld !== exp_v[k] || done !== (k == 12)) begin
        n_fail++;
        $display("FAIL bubble_cycle_%0d: got d=%h v=%b done=%b, want d=%h v=%b done=%b",
                 k, data_arr, data_vld, done, exp_d[k], exp_v[k], (k == 12));
      end
      case (k)
        1: begin in_valid = 1'b0; in_row = 32'h0; end
        3: begin in_valid = 1'b1; in_row = 32'hB1B2B3B4; end
        4: begin in_row = 32'hC1C2C3C4; in_last = 1'b1; end
        5: begin in_valid = 1'b0; in_last = 1'b0; in_row = 32'h0; end
        default: ;
      endcase
    end
  endtask

  // Reset after two accepted rows discards everything in flight.
  task automatic test_reset_mid_stream();
    in_valid = 1'b1;
    in_row   = 32'h99887766;
    in_last  = 1'b0;
    @(negedge clk);
    in_row = 32'h55443322;
    @(negedge clk);
    in_valid = 1'b0;
    in_row   = 32'h0;
    rst      = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({wt_ready, in_ready, control, wt_arr, data_arr, data_vld, busy, done} !== 70'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got wr=%b ir=%b ctl=%b wt=%h d=%h v=%b busy=%b done=%b, want all 0",
               wt_ready, in_ready, control, wt_arr, data_arr, data_vld, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (data_arr !== 32'h0 || wt_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: got d=%h wr=%b busy=%b, want d=0 wr=1 busy=1",
               data_arr, wt_ready, busy);
    end
  endtask

  initial begin
    rst      = 1'b1;
    wt_valid = 1'b0;
    wt_row   = 32'h0;
    in_valid = 1'b0;
    in_row   = 32'h0;
    in_last  = 1'b0;

    test_reset();
    test_weight_shift(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    test_wt_ignored();
    test_back_to_back();
    test_weight_shift(32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000);
    test_bubble();
    test_weight_shift(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF, 32'hFF00FF00);
    test_reset_mid_stream();
    test_weight_shift(32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D);
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a task stalls despite its own bounds.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
